// File: rtl/bounded_counter_scheduler.sv
// bounded_counter_scheduler: round-robin shared bounded up-counter; BCS_ASSERTIONS_EN adds embedded SVA checks
module bounded_counter_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_W     = 4,
  parameter int MAX_COUNT = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] target,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [CNT_W-1:0]         count,
  output logic                     busy,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       err
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);
  if (MAX_COUNT > 2**CNT_W-1) begin : g_bad_max
    $fatal(1, "MAX_COUNT exceeds counter range");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num
    $fatal(1, "NUM_REQ out of range");
  end
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] rr, rr_d, w_q, w_d, win, win_nxt, w_nxt;
  logic [CNT_W-1:0] tgt_q, tgt_d, count_d, win_tgt;
  logic [NUM_REQ-1:0] gnt_d, done_d, err_d, win_oh;
  logic found;
  // round-robin winner search starting at rr with wrap
  always_comb begin
    win = rr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(rr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win = PW'((int'(rr) + k) % NUM_REQ);
      end
    end
  end
  assign win_tgt = target[int'(win)*CNT_W +: CNT_W];
  assign win_oh = NUM_REQ'(1) << win;
  assign win_nxt = (win == PW'(NUM_REQ-1)) ? '0 : win + 1'b1;
  assign w_nxt = (w_q == PW'(NUM_REQ-1)) ? '0 : w_q + 1'b1;
  // next-state and next-output logic; done/err default to no pulse
  always_comb begin
    state_d = state_q;
    gnt_d = gnt;
    count_d = count;
    tgt_d = tgt_q;
    w_d = w_q;
    rr_d = rr;
    done_d = '0;
    err_d = '0;
    case (state_q)
      IDLE: if (found) begin
        if (win_tgt > MAX_C) begin
          err_d = win_oh;
          rr_d = win_nxt;
        end else begin
          gnt_d = win_oh;
          count_d = '0;
          tgt_d = win_tgt;
          w_d = win;
          state_d = COUNT;
        end
      end
      COUNT: if (!req[w_q]) begin
        gnt_d = '0;
        count_d = '0;
        rr_d = w_nxt;
        state_d = IDLE;
      end else if (count == tgt_q) begin
        done_d = gnt;
        state_d = DONE;
      end else begin
        count_d = count + 1'b1;
      end
      default: begin
        gnt_d = '0;
        count_d = '0;
        rr_d = w_nxt;
        state_d = IDLE;
      end
    endcase
  end
  // all outputs registered; reset suppresses any pending pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt <= '0;
      count <= '0;
      busy <= 1'b0;
      done <= '0;
      err <= '0;
      rr <= '0;
      w_q <= '0;
      tgt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt <= gnt_d;
      count <= count_d;
      busy <= state_d != IDLE;
      done <= done_d;
      err <= err_d;
      rr <= rr_d;
      w_q <= w_d;
      tgt_q <= tgt_d;
    end
  end
`ifdef BCS_ASSERTIONS_EN
  localparam int LIM = NUM_REQ*(MAX_COUNT+3);
  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_done_gnt: assert property (@(posedge clk) disable iff (reset) (done & ~gnt) == '0);
  a_done_pulse: assert property (@(posedge clk) disable iff (reset) (done & $past(done)) == '0);
  a_err_pulse: assert property (@(posedge clk) disable iff (reset) (err & $past(err)) == '0);
  a_count_max: assert property (@(posedge clk) disable iff (reset) count <= MAX_C);
  a_gnt_busy: assert property (@(posedge clk) disable iff (reset) |gnt |-> busy);
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_live
    int wait_cnt;
    // cycles requester i has waited without grant or rejection
    always_ff @(posedge clk) begin
      if (reset || !req[i] || gnt[i] || err[i]) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
    end
    a_live: assert property (@(posedge clk) disable iff (reset) wait_cnt <= LIM);
  end
`endif
endmodule

// File: tb/tb_bounded_counter_scheduler.sv
// tb_bounded_counter_scheduler: scoreboard bench with directed vectors for bounded_counter_scheduler
module tb_bounded_counter_scheduler;
  localparam logic [1:0] K_GNT = 2'd0, K_DONE = 2'd1, K_ERR = 2'd2;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] req = '0;
  logic [15:0] target = '0;
  logic [3:0] gnt, done, err, prev_gnt;
  logic [3:0] count;
  logic busy;
  int cyc = 0, checks = 0, passed = 0;
  typedef struct {logic [1:0] kind; logic [3:0] vec; logic [3:0] cnt; int at;} ev_t;
  ev_t exp_q[$];
  bounded_counter_scheduler #(.NUM_REQ(4), .CNT_W(4), .MAX_COUNT(10)) dut (
    .clk(clk), .reset(reset), .req(req), .target(target), .gnt(gnt),
    .count(count), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  // cycle index used to stamp observed events
  always @(posedge clk) cyc <= cyc + 1;
  task automatic expect_ev(input logic [1:0] k, input logic [3:0] v, input logic [3:0] c, input int at);
    exp_q.push_back('{k, v, c, at});
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, want, cyc);
  endtask
  task automatic observe(input logic [1:0] k, input logic [3:0] v, input logic [3:0] c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d vec=%b cnt=%0d cyc=%0d, none expected", k, v, c, cyc);
    end else begin
      e = exp_q.pop_front();
      if (k == e.kind && v == e.vec && c == e.cnt && cyc == e.at) passed++;
      else $display("FAIL event: got kind=%0d vec=%b cnt=%0d cyc=%0d want kind=%0d vec=%b cnt=%0d cyc=%0d",
                    k, v, c, cyc, e.kind, e.vec, e.cnt, e.at);
    end
  endtask
  // monitor: grant rises, done and err pulses are compared against the scoreboard
  always @(negedge clk) begin
    if (gnt != 4'b0 && gnt != prev_gnt) observe(K_GNT, gnt, count);
    if (done != 4'b0) observe(K_DONE, done, count);
    if (err != 4'b0) observe(K_ERR, err, count);
    prev_gnt <= gnt;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask
  initial begin
    int c0, c1;
    logic [3:0] v;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_after_reset", 32'({gnt, count, busy, done, err}), 0);
    end
    c0 = cyc;
    target = 16'h000A;
    req = 4'b0001;
    expect_ev(K_GNT, 4'b0001, 4'd0, c0 + 1);
    expect_ev(K_DONE, 4'b0001, 4'd10, c0 + 12);
    for (int k = 0; k <= 10; k++) begin
      tick(1);
      chk("run_count", 32'(count), k);
    end
    tick(1);
    req = 4'b0;
    tick(1);
    chk("post_done_idle", 32'({gnt, count, busy}), 0);
    do_reset();
    c0 = cyc;
    target = 16'h2222;
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      v = 4'(1 << (j % 4));
      expect_ev(K_GNT, v, 4'd0, c0 + 5*j + 1);
      expect_ev(K_DONE, v, 4'd2, c0 + 5*j + 4);
    end
    tick(24);
    req = 4'b0;
    tick(2);
    do_reset();
    c0 = cyc;
    target = 16'h0000;
    req = 4'b0010;
    expect_ev(K_GNT, 4'b0010, 4'd0, c0 + 1);
    expect_ev(K_DONE, 4'b0010, 4'd0, c0 + 2);
    tick(2);
    req = 4'b0;
    tick(1);
    c1 = cyc;
    target = 16'h0C00;
    req = 4'b0110;
    expect_ev(K_ERR, 4'b0100, 4'd0, c1 + 1);
    expect_ev(K_GNT, 4'b0010, 4'd0, c1 + 2);
    expect_ev(K_DONE, 4'b0010, 4'd0, c1 + 3);
    tick(1);
    chk("err_no_gnt", 32'(gnt), 0);
    req = 4'b0010;
    tick(2);
    req = 4'b0;
    tick(2);
    do_reset();
    c0 = cyc;
    target = 16'h8000;
    req = 4'b1000;
    expect_ev(K_GNT, 4'b1000, 4'd0, c0 + 1);
    tick(1);
    target = 16'h8001;
    req = 4'b1001;
    tick(3);
    chk("abort_count3", 32'(count), 3);
    req = 4'b0001;
    tick(1);
    chk("abort_outputs", 32'({gnt, count, busy, done}), 0);
    expect_ev(K_GNT, 4'b0001, 4'd0, c0 + 6);
    expect_ev(K_DONE, 4'b0001, 4'd1, c0 + 8);
    tick(3);
    req = 4'b0;
    tick(2);
    c0 = cyc;
    target = 16'h0008;
    req = 4'b0001;
    expect_ev(K_GNT, 4'b0001, 4'd0, c0 + 1);
    tick(6);
    chk("mid_count5", 32'(count), 5);
    reset = 1'b1;
    req = 4'b0;
    tick(1);
    chk("reset_mid_job", 32'({gnt, count, busy, done, err}), 0);
    reset = 1'b0;
    tick(4);
    chk("quiet_after_reset", 32'({gnt, count, busy, done, err}), 0);
    c1 = cyc;
    target = 16'h0000;
    req = 4'b0011;
    expect_ev(K_GNT, 4'b0001, 4'd0, c1 + 1);
    expect_ev(K_DONE, 4'b0001, 4'd0, c1 + 2);
    expect_ev(K_GNT, 4'b0010, 4'd0, c1 + 4);
    expect_ev(K_DONE, 4'b0010, 4'd0, c1 + 5);
    tick(2);
    req = 4'b0010;
    tick(3);
    req = 4'b0;
    tick(3);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL missing_events: got %0d pending, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
